// File: rtl/rv_fetch_if.sv
// Fetch-to-decode handshake: instruction stream out, redirect requests back in.
interface rv_fetch_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  instr_valid_o;
  logic [31:0]           instr_o;
  logic [ADDR_WIDTH-1:0] instr_pc_o;
  logic                  instr_ready_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_pc_i;

  modport master (
    output instr_valid_o, instr_o, instr_pc_o,
    input  instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  instr_valid_o, instr_o, instr_pc_o,
    output instr_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch front end: drives imem with the PC, buffers fetched words in a
// 2-entry queue and hands them to decode; redirects flush the queue and restart fetch.
module rv_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [31:0]           read_instr_i,
  output logic [31:0]           fetch_count_o,
  rv_fetch_if.master            dec
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  entry_t                q_q [2];
  entry_t                q_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [31:0]           fcnt_q, fcnt_d;
  logic                  pop, fetch;
  entry_t                head;

  assign head              = q_q[rd_ptr_q];
  assign dec.instr_valid_o = (count_q != 2'd0);
  assign dec.instr_o       = head.instr;
  assign dec.instr_pc_o    = head.pc;
  assign imem_addr_o       = {2'b00, pc_q[ADDR_WIDTH-1:2]};
  assign fetch_count_o     = fcnt_q;

  // A full queue may still accept a fetch when the head leaves in the same cycle.
  assign pop   = dec.instr_valid_o & dec.instr_ready_i & ~dec.redirect_i;
  assign fetch = fetch_en_i & ~dec.redirect_i & (~count_q[1] | pop);

  always_comb begin
    pc_d     = pc_q;
    q_d      = q_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    fcnt_d   = fcnt_q;
    if (dec.redirect_i) begin
      pc_d     = dec.redirect_pc_i & ~ADDR_WIDTH'(3);
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (fetch) begin
        q_d[wr_ptr_q] = '{pc: pc_q, instr: read_instr_i};
        wr_ptr_d      = ~wr_ptr_q;
        pc_d          = pc_q + ADDR_WIDTH'(4);
        fcnt_d        = fcnt_q + 32'd1;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, fetch} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      q_q[0]   <= '0;
      q_q[1]   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      fcnt_q   <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      q_q      <= q_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fcnt_q   <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Scoreboarded bench for rv_fetch_unit: expected {pc, instr} pushed per scenario,
// popped and compared whenever decode accepts the head.
module tb_rv_fetch_unit;

  logic        clk, reset, fetch_en;
  logic [63:0] imem_addr;
  logic [31:0] read_instr, fetch_count;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  rv_fetch_if #(.ADDR_WIDTH(64)) dif ();

  rv_fetch_unit #(.ADDR_WIDTH(64), .RESET_PC(64'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_en_i   (fetch_en),
    .imem_addr_o  (imem_addr),
    .read_instr_i (read_instr),
    .fetch_count_o(fetch_count),
    .dec          (dif)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] widx);
    case (widx)
      64'd0:   return 32'h0000_0013;
      64'd1:   return 32'h0010_0093;
      64'd2:   return 32'h0020_0113;
      64'd3:   return 32'h0030_0193;
      default: return 32'hA000_0000 | {4'h0, widx[27:0]};
    endcase
  endfunction

  assign read_instr = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc);
    sb.push_back('{pc: pc, instr: mem_word(pc >> 2)});
  endtask

  // Compare every accepted head against the scoreboard.
  always @(negedge clk) begin
    if (!reset && dif.instr_valid_o && dif.instr_ready_i && !dif.redirect_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, required no delivery",
                 dif.instr_pc_o, dif.instr_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dif.instr_pc_o !== e.pc || dif.instr_o !== e.instr) begin
          errors++;
          $display("FAIL pop_order: got pc=%h instr=%h, required pc=%h instr=%h",
                   dif.instr_pc_o, dif.instr_o, e.pc, e.instr);
        end
      end
    end
  end

  task automatic expect_drained(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || dif.instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending, valid=%b, required 0 pending, valid=0",
               name, sb.size(), dif.instr_valid_o);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    tick(); tick();
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", dif.instr_valid_o); end
    checks++;
    if (dif.instr_o !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h, required 0", dif.instr_o); end
    checks++;
    if (dif.instr_pc_o !== 64'h0) begin errors++; $display("FAIL rst_pc: got %h, required 0", dif.instr_pc_o); end
    checks++;
    if (imem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr: got %h, required 0", imem_addr); end
    checks++;
    if (fetch_count !== 32'h0) begin errors++; $display("FAIL rst_count: got %0d, required 0", fetch_count); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [4];
    words[0] = 32'h0000_0013; words[1] = 32'h0010_0093;
    words[2] = 32'h0020_0113; words[3] = 32'h0030_0193;
    for (int i = 0; i < 4; i++) push(64'(i * 4));
    fetch_en = 1'b1; dif.instr_ready_i = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) fetch_en = 1'b0;
      @(negedge clk);
      checks++;
      if (dif.instr_valid_o !== 1'b1 || dif.instr_pc_o !== 64'(i * 4) || dif.instr_o !== words[i]) begin
        errors++;
        $display("FAIL seq_head%0d: got valid=%b pc=%h instr=%h, required valid=1 pc=%h instr=%h",
                 i, dif.instr_valid_o, dif.instr_pc_o, dif.instr_o, 64'(i * 4), words[i]);
      end
    end
    checks++;
    if (fetch_count !== 32'd4 || imem_addr !== 64'd4) begin
      errors++;
      $display("FAIL seq_count: got count=%0d addr=%h, required count=4 addr=4", fetch_count, imem_addr);
    end
    expect_drained("seq");
  endtask

  task automatic test_backpressure();
    tick();
    reset = 1'b1; fetch_en = 1'b1; dif.instr_ready_i = 1'b0;
    tick();
    reset = 1'b0;
    push(64'h0); push(64'h4); push(64'h8);
    tick(); tick(); tick();
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b1 || dif.instr_pc_o !== 64'h0 || imem_addr !== 64'd2 || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL bp_full: got valid=%b pc=%h addr=%h count=%0d, required valid=1 pc=0 addr=2 count=2",
               dif.instr_valid_o, dif.instr_pc_o, imem_addr, fetch_count);
    end
    tick(); tick();
    @(negedge clk);
    checks++;
    if (imem_addr !== 64'd2 || dif.instr_pc_o !== 64'h0 || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL bp_hold: got addr=%h pc=%h count=%0d, required addr=2 pc=0 count=2",
               imem_addr, dif.instr_pc_o, fetch_count);
    end
    tick();
    dif.instr_ready_i = 1'b1;
    tick();
    fetch_en = 1'b0;
    expect_drained("bp");
    checks++;
    if (fetch_count !== 32'd3 || imem_addr !== 64'd3) begin
      errors++;
      $display("FAIL bp_count: got count=%0d addr=%h, required count=3 addr=3", fetch_count, imem_addr);
    end
  endtask

  task automatic test_redirect_full();
    tick();
    reset = 1'b1; fetch_en = 1'b1; dif.instr_ready_i = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b1 || dif.instr_pc_o !== 64'h0 || imem_addr !== 64'd2) begin
      errors++;
      $display("FAIL rd_prefull: got valid=%b pc=%h addr=%h, required valid=1 pc=0 addr=2",
               dif.instr_valid_o, dif.instr_pc_o, imem_addr);
    end
    tick();
    dif.redirect_i = 1'b1; dif.redirect_pc_i = 64'h40;
    tick();
    dif.redirect_i = 1'b0; dif.instr_ready_i = 1'b1;
    push(64'h40);
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b0 || imem_addr !== 64'h10 || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL rd_flush: got valid=%b addr=%h count=%0d, required valid=0 addr=10 count=2",
               dif.instr_valid_o, imem_addr, fetch_count);
    end
    tick();
    fetch_en = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b1 || dif.instr_pc_o !== 64'h40 || fetch_count !== 32'd3) begin
      errors++;
      $display("FAIL rd_target: got valid=%b pc=%h count=%0d, required valid=1 pc=40 count=3",
               dif.instr_valid_o, dif.instr_pc_o, fetch_count);
    end
    expect_drained("rd");
  endtask

  task automatic test_misaligned_redirect();
    tick();
    fetch_en = 1'b1;
    tick();
    dif.redirect_i = 1'b1; dif.redirect_pc_i = 64'h4E;
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b1 || dif.instr_pc_o !== 64'h44) begin
      errors++;
      $display("FAIL mis_head: got valid=%b pc=%h, required valid=1 pc=44", dif.instr_valid_o, dif.instr_pc_o);
    end
    tick();
    dif.redirect_i = 1'b0;
    push(64'h4C);
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b0 || imem_addr !== 64'h13 || fetch_count !== 32'd4) begin
      errors++;
      $display("FAIL mis_flush: got valid=%b addr=%h count=%0d, required valid=0 addr=13 count=4",
               dif.instr_valid_o, imem_addr, fetch_count);
    end
    tick();
    fetch_en = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.instr_pc_o !== 64'h4C || fetch_count !== 32'd5) begin
      errors++;
      $display("FAIL mis_target: got pc=%h count=%0d, required pc=4c count=5", dif.instr_pc_o, fetch_count);
    end
    expect_drained("mis");
  endtask

  task automatic test_fetch_en_toggle();
    tick();
    fetch_en = 1'b1;
    push(64'h50); push(64'h54);
    tick();
    tick();
    fetch_en = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b0 || imem_addr !== 64'h16) begin
      errors++;
      $display("FAIL fen_empty: got valid=%b addr=%h, required valid=0 addr=16", dif.instr_valid_o, imem_addr);
    end
    tick(); tick();
    fetch_en = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_addr !== 64'h16 || fetch_count !== 32'd7) begin
      errors++;
      $display("FAIL fen_hold: got addr=%h count=%0d, required addr=16 count=7", imem_addr, fetch_count);
    end
    push(64'h58); push(64'h5C);
    tick();
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b1 || dif.instr_pc_o !== 64'h58) begin
      errors++;
      $display("FAIL fen_resume: got valid=%b pc=%h, required valid=1 pc=58", dif.instr_valid_o, dif.instr_pc_o);
    end
    tick();
    fetch_en = 1'b0;
    expect_drained("fen");
    checks++;
    if (fetch_count !== 32'd9) begin
      errors++;
      $display("FAIL fen_count: got %0d, required 9", fetch_count);
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    tick();
    dif.instr_ready_i = 1'b0; fetch_en = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; fetch_en = 1'b0;
    dif.redirect_i = 1'b1; dif.redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b0 || imem_addr !== 64'h0 || fetch_count !== 32'd0 ||
        dif.instr_o !== 32'h0 || dif.instr_pc_o !== 64'h0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b addr=%h count=%0d instr=%h pc=%h, required all 0",
               dif.instr_valid_o, imem_addr, fetch_count, dif.instr_o, dif.instr_pc_o);
    end
    tick();
    dif.redirect_i = 1'b0; fetch_en = 1'b1; dif.instr_ready_i = 1'b1;
    push(64'hFFFF_FFFF_FFFF_FFFC); push(64'h0);
    @(negedge clk);
    checks++;
    if (imem_addr !== 64'h3FFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_addr: got %h, required 3fffffffffffffff", imem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (dif.instr_valid_o !== 1'b1 || dif.instr_pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top: got valid=%b pc=%h, required valid=1 pc=fffffffffffffffc",
               dif.instr_valid_o, dif.instr_pc_o);
    end
    tick();
    fetch_en = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.instr_pc_o !== 64'h0 || imem_addr !== 64'h1 || fetch_count !== 32'd2) begin
      errors++;
      $display("FAIL wrap_zero: got pc=%h addr=%h count=%0d, required pc=0 addr=1 count=2",
               dif.instr_pc_o, imem_addr, fetch_count);
    end
    expect_drained("wrap");
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b1;
    dif.instr_ready_i = 1'b1; dif.redirect_i = 1'b0; dif.redirect_pc_i = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_full();
    test_misaligned_redirect();
    test_fetch_en_toggle();
    test_reset_mid_and_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
